// File: rtl/sevenseg_frame_capture.sv
// Passive reader for a multiplexed 4-digit seven-segment bus: samples each digit once its
// registered {an,seg} pattern has dwelt SETTLE_CYCLES cycles and assembles 16-bit frames.
module sevenseg_frame_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        clear,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic [3:0]  digit_mask,
  output logic        err_pattern,
  output logic        err_anode
);

  typedef enum logic [1:0] {WAIT = 2'd0, SETTLE = 2'd1, HELD = 2'd2} state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic [15:0]      digits_r;

  logic             change_s;
  logic             strobe_s;
  logic [4:0]       dec_s;
  logic             single_s;
  logic             multi_s;
  logic [1:0]       idx_s;
  logic [3:0]       new_mask_s;
  logic [15:0]      merged_s;

  // Active-low segment pattern to {valid, nibble}
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return {1'b1, 4'h0};
      7'b1111001: return {1'b1, 4'h1};
      7'b0100100: return {1'b1, 4'h2};
      7'b0110000: return {1'b1, 4'h3};
      7'b0011001: return {1'b1, 4'h4};
      7'b0010010: return {1'b1, 4'h5};
      7'b0000010: return {1'b1, 4'h6};
      7'b1111000: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0010000: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b0000011: return {1'b1, 4'hB};
      7'b1000110: return {1'b1, 4'hC};
      7'b0100001: return {1'b1, 4'hD};
      7'b0000110: return {1'b1, 4'hE};
      7'b0001110: return {1'b1, 4'hF};
      default:    return 5'b00000;
    endcase
  endfunction

  // Change is judged on what the input register is about to load, so the counter
  // reads 1 on the first cycle the registered copy holds a new pattern.
  always_comb begin
    change_s = ({an, seg} != {an_r, seg_r});
    strobe_s = (state_r == SETTLE) && (cnt_r == CNT_W'(SETTLE_CYCLES));
    dec_s    = seg_decode(seg_r);
  end

  // Anode classification: which single digit is lit, or more than one
  always_comb begin
    single_s = 1'b1;
    idx_s    = 2'd0;
    case (an_r)
      4'b1110: idx_s = 2'd0;
      4'b1101: idx_s = 2'd1;
      4'b1011: idx_s = 2'd2;
      4'b0111: idx_s = 2'd3;
      default: single_s = 1'b0;
    endcase
    multi_s    = (an_r != 4'b1111) && !single_s;
    new_mask_s = digit_mask | (4'b0001 << idx_s);
    merged_s   = digits_r;
    merged_s[{idx_s, 2'b00} +: 4] = dec_s[3:0];
  end

  // Input register and settle FSM
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      an_r    <= 4'b1111;
      seg_r   <= 7'b1111111;
      state_r <= WAIT;
      cnt_r   <= '0;
    end else begin
      an_r  <= an;
      seg_r <= seg;
      case (state_r)
        WAIT, HELD: begin
          if (change_s) begin
            state_r <= SETTLE;
            cnt_r   <= CNT_W'(1);
          end
        end
        SETTLE: begin
          if (change_s) begin
            cnt_r <= CNT_W'(1);
          end else if (strobe_s) begin
            state_r <= HELD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= WAIT;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Digit capture, frame assembly and sticky error flags
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      value         <= 16'h0000;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      digit_mask    <= 4'b0000;
      err_pattern   <= 1'b0;
      err_anode     <= 1'b0;
      digits_r      <= 16'h0000;
    end else begin
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      if (clear) begin
        digit_mask  <= 4'b0000;
        err_pattern <= 1'b0;
        err_anode   <= 1'b0;
      end else if (strobe_s) begin
        if (multi_s) begin
          err_anode <= 1'b1;
        end else if (single_s) begin
          if (dec_s[4]) begin
            digits_r <= merged_s;
            if (new_mask_s == 4'b1111) begin
              value         <= merged_s;
              frame_valid   <= 1'b1;
              frame_changed <= (merged_s != value);
              digit_mask    <= 4'b0000;
            end else begin
              digit_mask <= new_mask_s;
            end
          end else begin
            err_pattern <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/sevenseg_frame_capture.md
Name: sevenseg_frame_capture

Overview:
Passive reader for the multiplexed 4-digit seven-segment bus (seg/an) driven by the processor's display scanner. It samples each digit once its anode/segment pattern has been stable, decodes the active-low segment pattern back to a hex nibble, and assembles a 16-bit value. It is used in the self-checking bench and in on-board loopback debug. It checks displayed register contents without relying on the display driver's internals.

Parameters:
SETTLE_CYCLES, 4, consecutive cycles the registered {an,seg} must hold unchanged before a digit is sampled; legal range 2..65535.
CNT_W, $clog2(SETTLE_CYCLES+1), settle counter width (derived).

Ports:
CLK100MHZ  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
seg  input  7  segment lines, active-low, seg[0]=a … seg[6]=g
an  input  4  anode lines, active-low, an[0]=rightmost digit
clear  input  1  synchronous: clears seen mask and sticky errors
value  output  16  last complete frame; an[i] digit -> value[4i+3:4i]
frame_valid  output  1  one-cycle pulse when value updates
frame_changed  output  1  one-cycle pulse with frame_valid when new value != previous value
digit_mask  output  4  digits captured in current frame (bit i = an[i])
err_pattern  output  1  sticky: sampled seg not in decode table
err_anode  output  1  sticky: sampled an had more than one low bit

Behaviour:
- Reset: value=16'h0000, frame_valid=0, frame_changed=0, digit_mask=0, err_pattern=0, err_anode=0. Settle counter=0, FSM=WAIT. All digit buffers=0.
- Input stage: {an,seg} is registered once (r_an, r_seg). All logic below uses the registered copy.
- FSM WAIT -> SETTLE on any cycle r_{an,seg} differs from the previous cycle's value. The counter reloads to 1.
- In SETTLE: counter increments while the input is unchanged. Any change reloads the counter to 1 and keeps the FSM in SETTLE. When the counter reaches SETTLE_CYCLES, a one-cycle sample strobe fires and the FSM moves to HELD.
- In HELD: no further samples. Any change goes to SETTLE with the counter at 1. Exactly one sample per stable dwell.
- The first dwell after reset counts too: reset state compares against r_{an,seg}=all-ones. A held non-blank pattern still gets sampled.
- On strobe:
  - r_an=4'b1111: blank, ignored.
  - Two or more bits of r_an low: err_anode<=1, nothing captured.
  - Exactly one bit i low and r_seg decodes: buf[i]<=nibble, digit_mask[i]<=1.
  - Exactly one bit i low and r_seg does not decode: err_pattern<=1, digit_mask unchanged.
- Decode (r_seg[6:0] -> nibble):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=b
  - 1000110=C, 0100001=d, 0000110=E, 0001110=F
  - Any other pattern is an error.
- Frame completion: when a strobe captures a digit making the mask 4'b1111, then at that edge:
  - value <= buffers including the new nibble;
  - frame_valid=1 for one cycle;
  - frame_changed=1 if the new value != the old value (first frame after reset compares to 0);
  - digit_mask <= 0.
- Re-capturing an already-seen digit before the frame completes overwrites its buffer. The mask is unchanged.
- Latency: an input held from edge k reaches r_* at k+1. The strobe is at cycle k+SETTLE_CYCLES. value/frame_valid are visible from edge k+SETTLE_CYCLES+1.
- clear: digit_mask<=0, err_pattern<=0, err_anode<=0; value is kept.
  - If clear and a strobe occur in the same cycle, clear wins for the mask and errors, and the sample is discarded.
  - The settle FSM is unaffected.
- rst_n low mid-frame: everything returns to reset values immediately, asynchronously. Partial buffers are lost.
- Glitches shorter than SETTLE_CYCLES never produce a sample.

Test Plan:
1. Scan an=1110/1101/1011/0111 with seg=0000000 (8), 0100100 (2), 0110000 (3), 1000000 (0), 10 cycles each. Expected: value=16'h0328, frame_valid pulses once after the 4th dwell, frame_changed=1.
2. Repeat the identical scan. Expected: frame_valid pulses, frame_changed=0, value=16'h0328.
3. Digit 0 shows seg=0000000 for 3 cycles, then 1111001 for 10 cycles (SETTLE_CYCLES=4). Expected: only '1' is captured, no error.
4. an=1100 held 10 cycles. Expected: err_anode=1, digit_mask unchanged. Pulse clear: err_anode=0.
5. an=1110 with seg=1111111 (not blank, invalid pattern). Expected: err_pattern=1, digit_mask[0]=0.
6. Capture digits 0-2 of 16'h1234, assert rst_n=0 for 1 cycle, then scan 16'h00AF fully. Expected: digit_mask=0 right after reset, final value=16'h00AF, one frame_valid.
